// File: rtl/counter_sequencer.sv
// Counter sequencer: issues one reset pulse and then STEP_COUNT advance pulses
// to a counter clock/reset controller. After each advance it waits for the
// consumer to acknowledge the settled counter before issuing the next one.
//
// Ports:
//   CLK             rising-edge clock
//   RST             asynchronous active-low reset
//   START           single-cycle request to run a sequence (accepted in IDLE only)
//   ABORT           terminates any sequence in progress
//   STEP_COUNT      number of advances, sampled when START is accepted
//   STEP_ACK        consumer acknowledge of STEP_VALID
//   ADVANCE_COUNTER registered advance request
//   RESET_COUNTER   registered reset request
//   STEP_VALID      counter settled after an advance, held until STEP_ACK
//   STEPS_DONE      advances completed in the current sequence
//   BUSY            high in every state except IDLE
//   DONE            one-cycle pulse on normal completion
module counter_sequencer #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] STEP_COUNT,
    input  logic             STEP_ACK,
    output logic             ADVANCE_COUNTER,
    output logic             RESET_COUNTER,
    output logic             STEP_VALID,
    output logic [CNT_W-1:0] STEPS_DONE,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned MAX_T = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W = (MAX_T < 2) ? 1 : $clog2(MAX_T);

    typedef enum logic [2:0] {
        IDLE,
        RST_PULSE,
        RST_GAP,
        ADV_PULSE,
        ADV_GAP,
        WAIT_ACK,
        FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               adv_q, adv_d;
    logic               rst_cnt_q, rst_cnt_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State register and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            steps_q   <= '0;
            adv_q     <= 1'b0;
            rst_cnt_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            steps_q   <= steps_d;
            adv_q     <= adv_d;
            rst_cnt_q <= rst_cnt_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, timer, counters; outputs are decoded from the next state
    // so that each registered output lines up exactly with its state.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        steps_d = steps_q;

        if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    count_d = STEP_COUNT;
                    steps_d = '0;
                    state_d = RST_PULSE;
                end
            end
            RST_PULSE: begin
                if (timer_q == '0) state_d = RST_GAP;
            end
            RST_GAP: begin
                if (timer_q == '0) state_d = (count_q == '0) ? FINISH : ADV_PULSE;
            end
            ADV_PULSE: begin
                if (timer_q == '0) begin
                    steps_d = steps_q + CNT_W'(1);
                    state_d = ADV_GAP;
                end
            end
            ADV_GAP: begin
                if (timer_q == '0) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Compare before any further increment so an all-ones count never wraps
                if (STEP_ACK) state_d = (steps_q == count_q) ? FINISH : ADV_PULSE;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything, including the step increment on pulse exit
        if (ABORT && (state_q != IDLE)) begin
            state_d = IDLE;
            steps_d = steps_q;
            count_d = count_q;
        end

        // Single timer, reloaded on every state entry
        if (state_d != state_q) begin
            case (state_d)
                RST_PULSE, ADV_PULSE: timer_d = TMR_W'(PULSE_CYCLES - 1);
                RST_GAP, ADV_GAP:     timer_d = TMR_W'(GAP_CYCLES - 1);
                default:              timer_d = '0;
            endcase
        end

        adv_d     = (state_d == ADV_PULSE);
        rst_cnt_d = (state_d == RST_PULSE);
        valid_d   = (state_d == WAIT_ACK);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FINISH);
    end

    assign ADVANCE_COUNTER = adv_q;
    assign RESET_COUNTER   = rst_cnt_q;
    assign STEP_VALID      = valid_q;
    assign STEPS_DONE      = steps_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;

endmodule
